// File: rtl/sync_arbiter_rr_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the clocked four-phase arbiter.
//   arb_state_t : transaction FSM states (IDLE, REQ, ACK, REL)
//   ptr_width() : width of the rotating pointer / owner index for M requesters
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } arb_state_t;

  // Index width for M requesters; never narrower than one bit.
  function automatic int ptr_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// sync_arbiter_rr_if
// Bundles the requester side and the consumer side of the arbiter.
//   r_i   [M]    requests from producers        a_i   [M] acknowledges to producers
//   d_i   [M*N]  producer data, slice k = k*N+:N
//   r_o          request to consumer            a_o       acknowledge from consumer
//   d_o   [N]    data to consumer               gnt_o [M] one-hot current owner
// Modports:
//   master : the arbiter itself
//   slave  : the surrounding producers/consumer
// ---------------------------------------------------------------------------
interface sync_arbiter_rr_if #(
  parameter int M = 2,
  parameter int N = 1
);

  logic [M-1:0]   r_i;
  logic [M-1:0]   a_i;
  logic [M*N-1:0] d_i;
  logic           r_o;
  logic           a_o;
  logic [N-1:0]   d_o;
  logic [M-1:0]   gnt_o;

  modport master (
    input  r_i, d_i, a_o,
    output a_i, r_o, d_o, gnt_o
  );

  modport slave (
    output r_i, d_i, a_o,
    input  a_i, r_o, d_o, gnt_o
  );

endinterface

// File: rtl/sync_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-mask priority encoder: the winner is the lowest
// requesting index at or above ptr, wrapping past M-1 back to 0.
//   req     [M]  request vector
//   ptr     [PW] search start (always < M)
//   win_oh  [M]  one-hot winner, zero when no request
//   win_idx [PW] binary index of the winner
//   win_any      at least one request present
// ---------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int M  = 2,
  parameter int PW = ptr_width(M)
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          win_any
);

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    int            cand_s;
    logic [PW-1:0] cand_idx_s;
    cand_s     = 0;
    cand_idx_s = '0;
    win_oh     = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    for (int i = 0; i < M; i++) begin
      // ptr < M and i < M, so one subtraction is enough to wrap for any M.
      cand_s     = int'(ptr) + i;
      cand_s     = (cand_s >= M) ? (cand_s - M) : cand_s;
      cand_idx_s = PW'(cand_s);
      if (req[cand_idx_s] && !win_any) begin
        win_oh[cand_idx_s] = 1'b1;
        win_idx            = cand_idx_s;
        win_any            = 1'b1;
      end else begin
        win_any = win_any;
      end
    end
  end

endmodule

// File: rtl/sync_arbiter_rr.sv
// ---------------------------------------------------------------------------
// sync_arbiter_rr
// Clocked M-way arbiter sharing one four-phase bundled-data consumer channel.
// One transaction at a time: grant, latch data, complete r+/a+/r-/a- on both
// sides, return to IDLE, re-arbitrate.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : sync_arbiter_rr_if.master (r_i, a_i, d_i, r_o, a_o, d_o, gnt_o)
// All outputs come straight from flops.
// Build option:
//   ARB_ROUND_ROBIN_EN defined   : rotating pointer, next search starts after
//                                  the last owner
//   ARB_ROUND_ROBIN_EN undefined : fixed priority, lowest index always wins
// ---------------------------------------------------------------------------
module sync_arbiter_rr
  import arb_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_arbiter_rr_if.master     bus
);

  localparam int PW = ptr_width(M);

  arb_state_t    state_r,  state_nxt_s;
  logic          r_o_r,    r_o_nxt_s;
  logic [M-1:0]  a_i_r,    a_i_nxt_s;
  logic [M-1:0]  gnt_r,    gnt_nxt_s;
  logic [N-1:0]  d_o_r,    d_o_nxt_s;
  logic [PW-1:0] owner_r,  owner_nxt_s;

  logic [PW-1:0] pick_ptr_s;
  logic [M-1:0]  win_oh_s;
  logic [PW-1:0] win_idx_s;
  logic          win_any_s;
  logic [N-1:0]  win_data_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_r, ptr_nxt_s;

  // Advance the pointer past the owner when its transaction fully closes.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if ((state_r == REL) && !bus.a_o) begin
      ptr_nxt_s = (owner_r == PW'(M - 1)) ? '0 : (owner_r + PW'(1));
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Rotating pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign pick_ptr_s = ptr_r;
`else
  assign pick_ptr_s = '0;
`endif

  rr_pick #(
    .M  (M),
    .PW (PW)
  ) u_pick (
    .req     (bus.r_i),
    .ptr     (pick_ptr_s),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s),
    .win_any (win_any_s)
  );

  // Data slice of the current winner (AND-OR mux over the one-hot grant).
  always_comb begin
    win_data_s = '0;
    for (int k = 0; k < M; k++) begin
      if (win_oh_s[k]) begin
        win_data_s = win_data_s | bus.d_i[k*N +: N];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a step fires.
  always_comb begin
    state_nxt_s = state_r;
    r_o_nxt_s   = r_o_r;
    a_i_nxt_s   = a_i_r;
    gnt_nxt_s   = gnt_r;
    d_o_nxt_s   = d_o_r;
    owner_nxt_s = owner_r;
    case (state_r)
      IDLE: begin
        // a_o is deliberately not looked at here.
        if (win_any_s) begin
          state_nxt_s = REQ;
          r_o_nxt_s   = 1'b1;
          gnt_nxt_s   = win_oh_s;
          owner_nxt_s = win_idx_s;
          d_o_nxt_s   = win_data_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // An owner dropping its request here is ignored; only a_o matters.
        if (bus.a_o) begin
          state_nxt_s = ACK;
          a_i_nxt_s   = gnt_r;
        end else begin
          state_nxt_s = REQ;
        end
      end
      ACK: begin
        if (!bus.r_i[owner_r]) begin
          state_nxt_s = REL;
          r_o_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ACK;
        end
      end
      REL: begin
        if (!bus.a_o) begin
          state_nxt_s = IDLE;
          a_i_nxt_s   = '0;
          gnt_nxt_s   = '0;
        end else begin
          state_nxt_s = REL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        r_o_nxt_s   = 1'b0;
        a_i_nxt_s   = '0;
        gnt_nxt_s   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      r_o_r   <= 1'b0;
      a_i_r   <= '0;
      gnt_r   <= '0;
      d_o_r   <= '0;
      owner_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      r_o_r   <= r_o_nxt_s;
      a_i_r   <= a_i_nxt_s;
      gnt_r   <= gnt_nxt_s;
      d_o_r   <= d_o_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  assign bus.r_o   = r_o_r;
  assign bus.a_i   = a_i_r;
  assign bus.gnt_o = gnt_r;
  assign bus.d_o   = d_o_r;

endmodule

// File: tb/tb_sync_arbiter_rr.sv
// Directed bench for sync_arbiter_rr: a 4-way/8-bit instance and a 3-way/8-bit
// instance share clock and reset. Expected grants depend on ARB_ROUND_ROBIN_EN.
module tb_sync_arbiter_rr;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_arbiter_rr_if #(.M(4), .N(8)) if4 ();
  sync_arbiter_rr_if #(.M(3), .N(8)) if3 ();

  sync_arbiter_rr #(.M(4), .N(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  sync_arbiter_rr #(.M(3), .N(8)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-delay consumer + owner for one transaction on the 4-way instance.
  // Returns observed grant/data and cycle counts; performs no checks.
  task automatic txn4(input logic [3:0] reraise, output logic [3:0] g, output logic [7:0] d,
                      output int wait_cyc, output int txn_cyc, output bit ok);
    ok = 1'b1; wait_cyc = 0; txn_cyc = 0;
    while (if4.r_o !== 1'b1 && wait_cyc < 10) begin tick(); wait_cyc++; end
    if (if4.r_o !== 1'b1) ok = 1'b0;
    g = if4.gnt_o; d = if4.d_o;
    if4.a_o = 1'b1;
    do begin tick(); txn_cyc++; end while (if4.a_i === 4'b0000 && txn_cyc < 10);
    if4.r_i = if4.r_i & ~g;
    do begin tick(); txn_cyc++; end while (if4.r_o !== 1'b0 && txn_cyc < 20);
    if4.a_o = 1'b0;
    do begin tick(); txn_cyc++; end while (if4.gnt_o !== 4'b0000 && txn_cyc < 30);
    if (if4.gnt_o !== 4'b0000) ok = 1'b0;
    if4.r_i = if4.r_i | (reraise & g);
  endtask

  // Close the current 3-way transaction (state REQ) with zero-delay partners.
  task automatic fin3();
    if3.a_o = 1'b1; tick();
    if3.r_i = if3.r_i & ~if3.gnt_o; tick();
    if3.a_o = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.r_i = 4'b1111; if4.a_o = 1'b0; if4.d_i = 32'hD3C2B1A0;
    if3.r_i = 3'b111;  if3.a_o = 1'b0; if3.d_i = 24'h939291;
    tick(); tick(); tick();
    checks++; if ({if4.r_o, if4.a_i, if4.gnt_o, if4.d_o} !== 17'd0) begin errors++;
      $display("FAIL reset_outputs4: got r_o=%b a_i=%b gnt=%b d_o=%h required all 0", if4.r_o, if4.a_i, if4.gnt_o, if4.d_o); end
    checks++; if ({if3.r_o, if3.a_i, if3.gnt_o, if3.d_o} !== 15'd0) begin errors++;
      $display("FAIL reset_outputs3: got r_o=%b a_i=%b gnt=%b d_o=%h required all 0", if3.r_o, if3.a_i, if3.gnt_o, if3.d_o); end
    rst = 1'b0; if3.r_i = 3'b000;
    tick();
    checks++; if (if4.gnt_o !== 4'b0001 || if4.r_o !== 1'b1 || if4.d_o !== 8'hA0) begin errors++;
      $display("FAIL reset_first_grant: got gnt=%b r_o=%b d_o=%h required 0001 1 a0", if4.gnt_o, if4.r_o, if4.d_o); end
    if4.a_o = 1'b1; tick();
    checks++; if (if4.a_i !== 4'b0001) begin errors++;
      $display("FAIL reset_first_ack: got a_i=%b required 0001", if4.a_i); end
    if4.r_i = 4'b0000; tick();
    if4.a_o = 1'b0; tick();
    checks++; if (if4.gnt_o !== 4'b0000 || if4.a_i !== 4'b0000) begin errors++;
      $display("FAIL reset_first_close: got gnt=%b a_i=%b required 0000 0000", if4.gnt_o, if4.a_i); end
  endtask

  task automatic test_single();
    if4.d_i = 32'h11A53344;
    if4.r_i = 4'b0100;
    tick();
    checks++; if (if4.gnt_o !== 4'b0100 || if4.r_o !== 1'b1 || if4.d_o !== 8'hA5 || if4.a_i !== 4'b0000) begin errors++;
      $display("FAIL single_grant: got gnt=%b r_o=%b d_o=%h a_i=%b required 0100 1 a5 0000", if4.gnt_o, if4.r_o, if4.d_o, if4.a_i); end
    if4.a_o = 1'b1; tick();
    checks++; if (if4.a_i !== 4'b0100 || if4.r_o !== 1'b1) begin errors++;
      $display("FAIL single_ack: got a_i=%b r_o=%b required 0100 1", if4.a_i, if4.r_o); end
    if4.r_i = 4'b0000; tick();
    checks++; if (if4.r_o !== 1'b0 || if4.a_i !== 4'b0100) begin errors++;
      $display("FAIL single_release: got r_o=%b a_i=%b required 0 0100", if4.r_o, if4.a_i); end
    if4.a_o = 1'b0; tick();
    checks++; if (if4.a_i !== 4'b0000 || if4.gnt_o !== 4'b0000 || if4.d_o !== 8'hA5) begin errors++;
      $display("FAIL single_idle: got a_i=%b gnt=%b d_o=%h required 0000 0000 a5", if4.a_i, if4.gnt_o, if4.d_o); end
    tick();
    checks++; if (if4.gnt_o !== 4'b0000 || if4.r_o !== 1'b0) begin errors++;
      $display("FAIL single_stay_idle: got gnt=%b r_o=%b required 0000 0", if4.gnt_o, if4.r_o); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    logic [3:0] g;
    logic [7:0] d;
    int         w, t;
    bit         ok;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_d = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    if4.d_i = 32'hD3C2B1A0;
    if4.r_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      txn4(4'b1111, g, d, w, t, ok);
      checks++; if (!ok || g !== exp_g[n] || d !== exp_d[n]) begin errors++;
        $display("FAIL fair_grant[%0d]: got ok=%0d gnt=%b d_o=%h required 1 %b %h", n, ok, g, d, exp_g[n], exp_d[n]); end
      checks++; if (w !== 1 || t !== 3) begin errors++;
        $display("FAIL fair_timing[%0d]: got wait=%0d txn=%0d required 1 3", n, w, t); end
    end
    if4.r_i = 4'b0000;
  endtask

  task automatic test_idle_noise();
    if4.a_o = 1'b1; tick(); tick();
    checks++; if (if4.gnt_o !== 4'b0000 || if4.a_i !== 4'b0000 || if4.r_o !== 1'b0) begin errors++;
      $display("FAIL idle_a_o: got gnt=%b a_i=%b r_o=%b required 0000 0000 0", if4.gnt_o, if4.a_i, if4.r_o); end
    if4.a_o = 1'b0;
  endtask

  task automatic test_pending();
    if4.d_i = 32'h0000C35A;
    if4.r_i = 4'b0001; tick();
    checks++; if (if4.gnt_o !== 4'b0001 || if4.d_o !== 8'h5A) begin errors++;
      $display("FAIL pend_first: got gnt=%b d_o=%h required 0001 5a", if4.gnt_o, if4.d_o); end
    if4.r_i = 4'b0011; if4.a_o = 1'b1; tick();
    checks++; if (if4.gnt_o !== 4'b0001 || if4.a_i !== 4'b0001 || if4.d_o !== 8'h5A) begin errors++;
      $display("FAIL pend_in_ack: got gnt=%b a_i=%b d_o=%h required 0001 0001 5a", if4.gnt_o, if4.a_i, if4.d_o); end
    if4.r_i = 4'b0010; tick();
    checks++; if (if4.gnt_o !== 4'b0001 || if4.r_o !== 1'b0 || if4.d_o !== 8'h5A) begin errors++;
      $display("FAIL pend_in_rel: got gnt=%b r_o=%b d_o=%h required 0001 0 5a", if4.gnt_o, if4.r_o, if4.d_o); end
    if4.a_o = 1'b0; tick();
    checks++; if (if4.gnt_o !== 4'b0000 || if4.d_o !== 8'h5A) begin errors++;
      $display("FAIL pend_idle: got gnt=%b d_o=%h required 0000 5a", if4.gnt_o, if4.d_o); end
    tick();
    checks++; if (if4.gnt_o !== 4'b0010 || if4.d_o !== 8'hC3 || if4.r_o !== 1'b1) begin errors++;
      $display("FAIL pend_granted: got gnt=%b d_o=%h r_o=%b required 0010 c3 1", if4.gnt_o, if4.d_o, if4.r_o); end
    if4.a_o = 1'b1; tick();
    if4.r_i = 4'b0000; tick();
    if4.a_o = 1'b0; tick();
  endtask

  task automatic test_wrap();
    logic [2:0] exp3;
`ifdef ARB_ROUND_ROBIN_EN
    exp3 = 3'b100;
`else
    exp3 = 3'b001;
`endif
    if3.d_i = 24'h939291;
    if3.r_i = 3'b100; tick();
    checks++; if (if3.gnt_o !== 3'b100 || if3.d_o !== 8'h93) begin errors++;
      $display("FAIL wrap_idx2: got gnt=%b d_o=%h required 100 93", if3.gnt_o, if3.d_o); end
    fin3();
    checks++; if (if3.gnt_o !== 3'b000 || if3.a_i !== 3'b000) begin errors++;
      $display("FAIL wrap_close: got gnt=%b a_i=%b required 000 000", if3.gnt_o, if3.a_i); end
    if3.r_i = 3'b011; tick();
    checks++; if (if3.gnt_o !== 3'b001 || if3.d_o !== 8'h91) begin errors++;
      $display("FAIL wrap_to_0: got gnt=%b d_o=%h required 001 91", if3.gnt_o, if3.d_o); end
    fin3();
    if3.r_i = 3'b101; tick();
    checks++; if (if3.gnt_o !== exp3) begin errors++;
      $display("FAIL wrap_after_0: got gnt=%b required %b", if3.gnt_o, exp3); end
    fin3();
    if3.r_i = 3'b000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 4'b0100; exp_d = 8'h66;
`else
    exp_g = 4'b0010; exp_d = 8'h77;
`endif
    if4.d_i = 32'h44667788;
    if4.r_i = 4'b0110; tick();
    checks++; if (if4.gnt_o !== exp_g || if4.d_o !== exp_d) begin errors++;
      $display("FAIL mid_grant: got gnt=%b d_o=%h required %b %h", if4.gnt_o, if4.d_o, exp_g, exp_d); end
    if4.a_o = 1'b1; tick();
    checks++; if (if4.a_i !== exp_g) begin errors++;
      $display("FAIL mid_ack: got a_i=%b required %b", if4.a_i, exp_g); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({if4.r_o, if4.a_i, if4.gnt_o, if4.d_o} !== 17'd0) begin errors++;
      $display("FAIL mid_reset: got r_o=%b a_i=%b gnt=%b d_o=%h required all 0", if4.r_o, if4.a_i, if4.gnt_o, if4.d_o); end
    if4.a_o = 1'b0; tick();
    checks++; if (if4.gnt_o !== 4'b0010 || if4.d_o !== 8'h77 || if4.r_o !== 1'b1) begin errors++;
      $display("FAIL mid_regrant: got gnt=%b d_o=%h r_o=%b required 0010 77 1", if4.gnt_o, if4.d_o, if4.r_o); end
    if4.a_o = 1'b1; tick();
    if4.r_i = 4'b0000; tick();
    if4.a_o = 1'b0; tick();
    checks++; if (if4.gnt_o !== 4'b0000 || if4.r_o !== 1'b0 || if4.a_i !== 4'b0000) begin errors++;
      $display("FAIL mid_close: got gnt=%b r_o=%b a_i=%b required 0000 0 0000", if4.gnt_o, if4.r_o, if4.a_i); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fairness();
    test_idle_noise();
    test_pending();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
